// File: rtl/lieat_exu_com_trapctrl.sv
// Arbitrates the machine-mode CSR port between trap entry, mret and EXU CSR instructions.
// CSR instructions complete in the accept cycle; trap redirects in cycle 5, mret in cycle 4.
// Lower-priority requesters see ready=0 while a higher source is valid or a sequence runs.
module lieat_exu_com_trapctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            csr_req_valid,
    output logic            csr_req_ready,
    input  logic            csr_req_write,
    input  logic            csr_req_read,
    input  logic [11:0]     csr_req_idx,
    input  logic [XLEN-1:0] csr_req_wdata,
    output logic [XLEN-1:0] csr_resp_rdata,
    input  logic            trap_valid,
    output logic            trap_ready,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    output logic            mret_ready,
    output logic            csr_ena,
    output logic            csr_write,
    output logic            csr_read,
    output logic [11:0]     csr_idx,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [11:0]     csr_idx2,
    output logic [XLEN-1:0] csr_wdata2,
    output logic            flush_valid,
    output logic [XLEN-1:0] flush_pc,
    output logic            busy
);

    typedef enum logic [3:0] {
        IDLE, T_RDST, T_WR, T_WRST, T_VEC, M_RDST, M_WRST, M_EPC, REDIR
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    state_t          r_state;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_target;

    logic            w_idle;
    logic            w_csr_acc;
    logic [XLEN-1:0] w_trap_mst;
    logic [XLEN-1:0] w_mret_mst;

    // Gated by rstn so every output reads 0 while reset is held.
    assign w_idle        = rstn & (r_state == IDLE);
    assign trap_ready    = w_idle;
    assign mret_ready    = w_idle & ~trap_valid;
    assign csr_req_ready = w_idle & ~trap_valid & ~mret_valid;
    assign w_csr_acc     = csr_req_valid & csr_req_ready;
    assign busy          = (r_state != IDLE);

    always_comb begin
        w_trap_mst        = r_mstatus;
        w_trap_mst[7]     = r_mstatus[3];
        w_trap_mst[3]     = 1'b0;
        w_trap_mst[12:11] = 2'b11;
        w_mret_mst        = r_mstatus;
        w_mret_mst[3]     = r_mstatus[7];
        w_mret_mst[7]     = 1'b1;
        w_mret_mst[12:11] = 2'b11;
    end

    always_comb begin
        csr_ena        = 1'b0;
        csr_write      = 1'b0;
        csr_read       = 1'b0;
        csr_idx        = 12'h000;
        csr_wdata      = '0;
        csr_idx2       = 12'h000;
        csr_wdata2     = '0;
        csr_resp_rdata = '0;
        flush_valid    = 1'b0;
        flush_pc       = '0;
        case (r_state)
            IDLE: begin
                if (w_csr_acc) begin
                    csr_ena        = 1'b1;
                    csr_write      = csr_req_write;
                    csr_read       = csr_req_read;
                    csr_idx        = csr_req_idx;
                    csr_wdata      = csr_req_wdata;
                    csr_resp_rdata = csr_rdata;
                end
            end
            T_RDST, M_RDST: begin
                csr_ena  = 1'b1;
                csr_read = 1'b1;
                csr_idx  = CSR_MSTATUS;
            end
            T_WR: begin
                csr_ena    = 1'b1;
                csr_write  = 1'b1;
                csr_idx    = CSR_MCAUSE;
                csr_wdata  = r_cause;
                csr_idx2   = CSR_MEPC;
                csr_wdata2 = r_pc;
            end
            T_WRST: begin
                csr_ena   = 1'b1;
                csr_write = 1'b1;
                csr_idx   = CSR_MSTATUS;
                csr_wdata = w_trap_mst;
            end
            M_WRST: begin
                csr_ena   = 1'b1;
                csr_write = 1'b1;
                csr_idx   = CSR_MSTATUS;
                csr_wdata = w_mret_mst;
            end
            T_VEC: begin
                csr_ena  = 1'b1;
                csr_read = 1'b1;
                csr_idx  = CSR_MTVEC;
            end
            M_EPC: begin
                csr_ena  = 1'b1;
                csr_read = 1'b1;
                csr_idx  = CSR_MEPC;
            end
            REDIR: begin
                flush_valid = 1'b1;
                flush_pc    = r_target;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cause   <= '0;
            r_pc      <= '0;
            r_mstatus <= '0;
            r_target  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (trap_valid) begin
                        r_cause <= trap_cause;
                        r_pc    <= trap_pc;
                        r_state <= T_RDST;
                    end else if (mret_valid) begin
                        r_state <= M_RDST;
                    end
                end
                T_RDST: begin
                    r_mstatus <= csr_rdata;
                    r_state   <= T_WR;
                end
                T_WR:   r_state <= T_WRST;
                T_WRST: r_state <= T_VEC;
                T_VEC: begin
                    // Direct mode only: vectored mode bits are dropped.
                    r_target <= {csr_rdata[XLEN-1:2], 2'b00};
                    r_state  <= REDIR;
                end
                M_RDST: begin
                    r_mstatus <= csr_rdata;
                    r_state   <= M_WRST;
                end
                M_WRST: r_state <= M_EPC;
                M_EPC: begin
                    r_target <= {csr_rdata[XLEN-1:1], 1'b0};
                    r_state  <= REDIR;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lieat_exu_com_trapctrl.sv
// Bench for lieat_exu_com_trapctrl: CSR file model, directed sequences and random traffic vs a plan-based model.
module tb_lieat_exu_com_trapctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        csr_req_valid, csr_req_ready, csr_req_write, csr_req_read;
    logic [11:0] csr_req_idx;
    logic [31:0] csr_req_wdata, csr_resp_rdata;
    logic        trap_valid, trap_ready;
    logic [31:0] trap_cause, trap_pc;
    logic        mret_valid, mret_ready;
    logic        csr_ena, csr_write, csr_read;
    logic [11:0] csr_idx, csr_idx2;
    logic [31:0] csr_wdata, csr_rdata, csr_wdata2;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        busy;

    always #5 clk = ~clk;

    lieat_exu_com_trapctrl #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn),
        .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
        .csr_req_write(csr_req_write), .csr_req_read(csr_req_read),
        .csr_req_idx(csr_req_idx), .csr_req_wdata(csr_req_wdata),
        .csr_resp_rdata(csr_resp_rdata),
        .trap_valid(trap_valid), .trap_ready(trap_ready),
        .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_valid(mret_valid), .mret_ready(mret_ready),
        .csr_ena(csr_ena), .csr_write(csr_write), .csr_read(csr_read),
        .csr_idx(csr_idx), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_idx2(csr_idx2), .csr_wdata2(csr_wdata2),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .busy(busy)
    );

    // CSR file: combinational read, secondary write wins on address clash.
    logic [31:0] f_st, f_tv, f_ep, f_ca;
    always_comb begin
        case (csr_idx)
            12'h300: csr_rdata = f_st;
            12'h305: csr_rdata = f_tv;
            12'h341: csr_rdata = f_ep;
            12'h342: csr_rdata = f_ca;
            default: csr_rdata = 32'h0;
        endcase
    end
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_st <= 0; f_tv <= 0; f_ep <= 0; f_ca <= 0;
        end else if (csr_ena && csr_write) begin
            case (csr_idx)
                12'h300: f_st <= csr_wdata;
                12'h305: f_tv <= csr_wdata;
                12'h341: f_ep <= csr_wdata;
                12'h342: f_ca <= csr_wdata;
                default: ;
            endcase
            case (csr_idx2)
                12'h300: f_st <= csr_wdata2;
                12'h305: f_tv <= csr_wdata2;
                12'h341: f_ep <= csr_wdata2;
                12'h342: f_ca <= csr_wdata2;
                default: ;
            endcase
        end
    end

    typedef struct packed {
        logic        trdy, mrdy, crdy, ena, wr, rd;
        logic [11:0] idx;
        logic [31:0] wdata;
        logic [11:0] idx2;
        logic [31:0] wdata2;
        logic        flush;
        logic [31:0] fpc;
        logic [31:0] resp;
        logic        busy;
    } obs_t;

    int checks = 0;
    int errors = 0;
    int n_flush = 0;
    obs_t s;

    // Reference model: architectural CSR values plus a script of expected sequence cycles.
    logic [31:0] m_st, m_tv, m_ep, m_ca;
    obs_t plan[$];
    logic m_acc_t, m_acc_m, m_acc_c;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [11:0] idx);
        case (idx)
            12'h300: return m_st;
            12'h305: return m_tv;
            12'h341: return m_ep;
            12'h342: return m_ca;
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_wr(input logic [11:0] idx, input logic [31:0] v);
        case (idx)
            12'h300: m_st = v;
            12'h305: m_tv = v;
            12'h341: m_ep = v;
            12'h342: m_ca = v;
            default: ;
        endcase
    endtask

    task automatic ref_reset();
        m_st = 0; m_tv = 0; m_ep = 0; m_ca = 0;
        plan.delete();
    endtask

    function automatic obs_t op(input logic wr, input logic rd, input logic [11:0] idx,
                                input logic [31:0] wd);
        obs_t o = '0;
        o.ena = 1'b1; o.wr = wr; o.rd = rd; o.idx = idx; o.wdata = wd; o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t redir(input logic [31:0] tgt);
        obs_t o = '0;
        o.flush = 1'b1; o.fpc = tgt; o.busy = 1'b1;
        return o;
    endfunction

    task automatic model(output obs_t e);
        logic [31:0] old, nxt;
        obs_t w;
        e = '0;
        m_acc_t = 0; m_acc_m = 0; m_acc_c = 0;
        if (plan.size() > 0) begin
            e = plan.pop_front();
        end else begin
            e.trdy = 1'b1;
            e.mrdy = !trap_valid;
            e.crdy = !trap_valid && !mret_valid;
            if (trap_valid) begin
                m_acc_t = 1;
                old = m_st;
                nxt = (old & ~32'h1888) | 32'h1800 | (old[3] ? 32'h80 : 32'h0);
                plan.push_back(op(0, 1, 12'h300, 0));
                w = op(1, 0, 12'h342, trap_cause);
                w.idx2 = 12'h341; w.wdata2 = trap_pc;
                plan.push_back(w);
                plan.push_back(op(1, 0, 12'h300, nxt));
                plan.push_back(op(0, 1, 12'h305, 0));
                plan.push_back(redir(m_tv & ~32'h3));
                m_ca = trap_cause; m_ep = trap_pc; m_st = nxt;
            end else if (mret_valid) begin
                m_acc_m = 1;
                old = m_st;
                nxt = (old & ~32'h1888) | 32'h1880 | (old[7] ? 32'h8 : 32'h0);
                plan.push_back(op(0, 1, 12'h300, 0));
                plan.push_back(op(1, 0, 12'h300, nxt));
                plan.push_back(op(0, 1, 12'h341, 0));
                plan.push_back(redir(m_ep & ~32'h1));
                m_st = nxt;
            end else if (csr_req_valid) begin
                m_acc_c = 1;
                e.ena = 1'b1; e.wr = csr_req_write; e.rd = csr_req_read;
                e.idx = csr_req_idx; e.wdata = csr_req_wdata;
                e.resp = ref_rd(csr_req_idx);
                if (csr_req_write) ref_wr(csr_req_idx, csr_req_wdata);
            end
        end
    endtask

    task automatic sample();
        s = '0;
        s.trdy = trap_ready; s.mrdy = mret_ready; s.crdy = csr_req_ready;
        s.ena = csr_ena; s.wr = csr_write; s.rd = csr_read;
        s.idx = csr_idx; s.wdata = csr_wdata; s.idx2 = csr_idx2; s.wdata2 = csr_wdata2;
        s.flush = flush_valid; s.fpc = flush_pc; s.resp = csr_resp_rdata; s.busy = busy;
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic cyc();
        obs_t e;
        #1;
        sample();
        model(e);
        chk("cycle", s, e);
        if (s.flush) n_flush++;
        @(negedge clk);
    endtask

    task automatic csr_op(input logic wr, input logic rd, input logic [11:0] idx, input logic [31:0] wd);
        csr_req_valid = 1; csr_req_write = wr; csr_req_read = rd;
        csr_req_idx = idx; csr_req_wdata = wd;
        cyc();
        csr_req_valid = 0; csr_req_write = 0; csr_req_read = 0;
    endtask

    typedef struct {
        logic        wr, rd;
        logic [11:0] idx;
        logic [31:0] wdata, resp;
    } vec_t;
    vec_t vt[7];

    int acc_m_cyc, acc_c_cyc;
    logic p_t, p_m, p_c;

    initial begin
        vt[0] = '{1, 0, 12'h305, 32'h80000103, 32'h0};
        vt[1] = '{0, 1, 12'h305, 32'h0,        32'h80000103};
        vt[2] = '{1, 1, 12'h341, 32'h12345677, 32'h0};
        vt[3] = '{0, 1, 12'h341, 32'h0,        32'h12345677};
        vt[4] = '{1, 0, 12'h7C1, 32'hDEADBEEF, 32'h0};
        vt[5] = '{1, 1, 12'h300, 32'h8,        32'h0};
        vt[6] = '{0, 1, 12'h300, 32'h0,        32'h8};

        rstn = 0;
        csr_req_valid = 0; csr_req_write = 0; csr_req_read = 0; csr_req_idx = 0; csr_req_wdata = 0;
        trap_valid = 0; trap_cause = 0; trap_pc = 0; mret_valid = 0;
        ref_reset();
        repeat (2) @(negedge clk);
        #1; sample();
        chk("reset_outputs", s, '0);
        @(negedge clk);
        rstn = 1;

        // CSR instruction table
        for (int i = 0; i < 7; i++) begin
            csr_req_valid = 1; csr_req_write = vt[i].wr; csr_req_read = vt[i].rd;
            csr_req_idx = vt[i].idx; csr_req_wdata = vt[i].wdata;
            cyc();
            chk("csr_vec_resp", 160'(s.resp), 160'(vt[i].resp));
            chk("csr_vec_acc", 160'({s.crdy, s.ena, s.flush}), 160'(3'b110));
        end
        csr_req_valid = 0; csr_req_write = 0; csr_req_read = 0;
        cyc();

        // Trap entry with mstatus=0x8
        trap_valid = 1; trap_cause = 32'hB; trap_pc = 32'h80000040;
        cyc();
        chk("trap_accept", 160'({s.trdy, s.busy}), 160'(2'b10));
        trap_valid = 0;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c == 1) chk("trap_c1_rdst", 160'({s.rd, s.wr, s.idx}), 160'({2'b10, 12'h300}));
            if (c == 2) chk("trap_c2_wr", 160'({s.idx, s.wdata, s.idx2, s.wdata2}),
                            160'({12'h342, 32'hB, 12'h341, 32'h80000040}));
            if (c == 3) chk("trap_c3_mst", 160'({s.wr, s.idx, s.wdata}), 160'({1'b1, 12'h300, 32'h1880}));
            if (c == 5) chk("trap_c5_flush", 160'({s.flush, s.fpc}), 160'({1'b1, 32'h80000100}));
            if (c == 6) chk("trap_c6_idle", 160'({s.busy, s.trdy}), 160'(2'b01));
        end

        // Mret back to the trapped pc
        mret_valid = 1;
        cyc();
        chk("mret_accept", 160'(s.mrdy), 160'(1));
        mret_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 2) chk("mret_c2_mst", 160'({s.wr, s.idx, s.wdata}), 160'({1'b1, 12'h300, 32'h1888}));
            if (c == 4) chk("mret_c4_flush", 160'({s.flush, s.fpc}), 160'({1'b1, 32'h80000040}));
        end
        cyc();

        // All three requests at once
        trap_valid = 1; trap_cause = 32'h3; trap_pc = 32'h80000200;
        mret_valid = 1;
        csr_req_valid = 1; csr_req_read = 1; csr_req_write = 0; csr_req_idx = 12'h342; csr_req_wdata = 0;
        cyc();
        chk("prio_readies", 160'({s.trdy, s.mrdy, s.crdy}), 160'(3'b100));
        trap_valid = 0;
        acc_m_cyc = -1; acc_c_cyc = -1;
        for (int c = 1; c <= 20 && csr_req_valid; c++) begin
            cyc();
            if (s.mrdy && mret_valid) begin acc_m_cyc = c; mret_valid = 0; end
            if (s.crdy && csr_req_valid) begin acc_c_cyc = c; csr_req_valid = 0; csr_req_read = 0; end
        end
        csr_req_valid = 0; mret_valid = 0;
        chk("prio_mret_cycle", 160'(acc_m_cyc), 160'(6));
        chk("prio_csr_cycle", 160'(acc_c_cyc), 160'(11));

        // Reset pulled during T_WR
        trap_valid = 1; trap_cause = 32'h7; trap_pc = 32'h00001234;
        cyc();
        trap_valid = 0;
        cyc();
        #1; sample();
        chk("rst_in_t_wr", 160'(s.idx2), 160'(12'h341));
        rstn = 0;
        #1; sample();
        chk("rst_abandon", s, '0);
        ref_reset();
        n_flush = 0;
        @(negedge clk); @(negedge clk);
        rstn = 1;
        repeat (6) cyc();
        chk("rst_no_flush", 160'(n_flush), 160'(0));
        csr_op(0, 1, 12'h341, 0);
        chk("rst_mepc_zero", 160'(s.resp), 160'(0));
        csr_op(0, 1, 12'h342, 0);
        chk("rst_mcause_zero", 160'(s.resp), 160'(0));

        // Random traffic: requesters hold valid and fields until accepted
        p_t = 0; p_m = 0; p_c = 0;
        for (int n = 0; n < 600; n++) begin
            if (!p_t && $urandom_range(0, 19) == 0) begin
                p_t = 1; trap_cause = $urandom; trap_pc = $urandom;
            end
            if (!p_m && $urandom_range(0, 11) == 0) p_m = 1;
            if (!p_c && $urandom_range(0, 2) == 0) begin
                p_c = 1;
                csr_req_write = 1'($urandom); csr_req_read = 1'($urandom); csr_req_wdata = $urandom;
                case ($urandom_range(0, 4))
                    0: csr_req_idx = 12'h300;
                    1: csr_req_idx = 12'h305;
                    2: csr_req_idx = 12'h341;
                    3: csr_req_idx = 12'h342;
                    default: csr_req_idx = 12'h7C1;
                endcase
            end
            trap_valid = p_t; mret_valid = p_m; csr_req_valid = p_c;
            cyc();
            if (m_acc_t) p_t = 0;
            if (m_acc_m) p_m = 0;
            if (m_acc_c) p_c = 0;
        end
        trap_valid = 0; mret_valid = 0; csr_req_valid = 0;
        repeat (8) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t: actual=running expected=finished", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lieat_exu_com_trapctrl.md
Name: lieat_exu_com_trapctrl

Overview:
- Sequencer and arbiter in front of the machine-mode CSR register file (mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342).
- Shares the single CSR access port between three sources, in fixed priority: trap entry (highest), mret, then ordinary CSR instructions from the EXU.
- Runs multi-cycle trap and mret sequences that read/modify/write the CSRs, then issues a one-cycle fetch redirect.

Parameters:
- XLEN, 32, data width of CSRs and PCs.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- csr_req_valid  in  1  EXU CSR instruction request
- csr_req_ready  out  1  request accepted this cycle
- csr_req_write  in  1  instruction writes the CSR
- csr_req_read  in  1  instruction reads the CSR
- csr_req_idx  in  12  CSR address
- csr_req_wdata  in  XLEN  write data
- csr_resp_rdata  out  XLEN  read data, valid in the accept cycle
- trap_valid  in  1  exception/interrupt entry request
- trap_ready  out  1  trap accepted
- trap_cause  in  XLEN  mcause value
- trap_pc  in  XLEN  mepc value
- mret_valid  in  1  mret request
- mret_ready  out  1  mret accepted
- csr_ena  out  1  CSR port enable
- csr_write  out  1  CSR write
- csr_read  out  1  CSR read
- csr_idx  out  12  primary CSR address
- csr_wdata  out  XLEN  primary write data
- csr_rdata  in  XLEN  combinational read data from the CSR file
- csr_idx2  out  12  secondary write address (its write data has priority in the CSR file)
- csr_wdata2  out  XLEN  secondary write data
- flush_valid  out  1  one-cycle fetch redirect
- flush_pc  out  XLEN  redirect target
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, T_RDST, T_WR, T_WRST, T_VEC, M_RDST, M_WRST, M_EPC, REDIR.
- Reset (asynchronous, rstn=0):
  - state=IDLE.
  - Latched cause, pc, mstatus and target registers = 0.
  - All outputs = 0.
  - Reset mid-sequence abandons the sequence; no further CSR writes or flush are issued.
- Ready signals:
  - trap_ready = (state==IDLE).
  - mret_ready = IDLE & ~trap_valid.
  - csr_req_ready = IDLE & ~trap_valid & ~mret_valid.
  - Simultaneous requests: only the highest priority is accepted; the others stay pending and unacknowledged.
- CSR instruction (IDLE, accepted):
  - Single cycle, passthrough: csr_ena=1, csr_write/csr_read/csr_idx/csr_wdata = request fields.
  - csr_resp_rdata = csr_rdata in the same cycle; it is 0 in all other cycles.
- csr_idx2 default: driven 12'h000 in every cycle that is not T_WR, so no unintended secondary write occurs. csr_wdata2 = 0 outside T_WR.
- Trap sequence (accept at cycle 0; latch cause and pc; go to T_RDST):
  - T_RDST: read 0x300; latch csr_rdata as old mstatus.
  - T_WR: write idx=0x342 with cause, and idx2=0x341 with pc, in one cycle.
  - T_WRST: write 0x300 with the old value modified:
    - bit7 MPIE = old bit3 MIE
    - bit3 MIE = 0
    - bits[12:11] MPP = 2'b11
    - all other bits unchanged.
  - T_VEC: read 0x305; latch target = {mtvec[XLEN-1:2], 2'b00} (direct mode only).
  - REDIR: flush_valid=1, flush_pc=target, no CSR access; then IDLE.
  - Resulting timing: flush_valid in cycle 5; next request can be accepted in cycle 6.
- Mret sequence (accept at cycle 0):
  - M_RDST: read 0x300; latch old mstatus.
  - M_WRST: write 0x300 with MIE = old MPIE, MPIE = 1, MPP = 2'b11, all other bits unchanged.
  - M_EPC: read 0x341; latch target = {mepc[XLEN-1:1], 1'b0}.
  - REDIR: flush as above; then IDLE.
  - Resulting timing: flush_valid in cycle 4.
- Port encoding in sequence states: csr_ena=1 in every sequence state except REDIR; csr_read or csr_write is asserted according to the step, never both.
- flush_valid is high only in REDIR, for exactly one cycle per accepted trap or mret.
- Requests arriving while busy are held off (ready=0) and are not lost; the requester keeps valid asserted.

Test Plan:
- After reset: CSR write 0x305 = 0x80000103, then CSR read 0x305 -> csr_resp_rdata = 0x80000103 in the accept cycle; flush_valid stays 0.
- mstatus preset to 0x8; trap with cause=0xB, pc=0x80000040:
  - cycle 1: read 0x300;
  - cycle 2: idx=0x342/wdata=0xB with idx2=0x341/wdata2=0x80000040;
  - cycle 3: mstatus write 0x1880;
  - cycle 5: flush_valid=1, flush_pc=0x80000100.
- mret following that trap:
  - mstatus 0x1880 -> 0x1888 written in cycle 2;
  - flush_valid in cycle 4 with flush_pc=0x80000040.
- trap_valid, mret_valid and csr_req_valid all raised in one IDLE cycle:
  - only trap_ready=1;
  - mret is accepted the first cycle after returning to IDLE;
  - the CSR request is accepted only after the mret sequence completes.
- rstn pulled low during T_WR: state IDLE, csr_ena=0, flush_valid never asserted, busy=0; after release, mepc and mcause read back 0.
- csr_idx2 monitor: 12'h000 in every cycle except T_WR.
